stopwatch_display_scan: RTL and testbench

Downstream consumer of the stopwatch counter. Takes its six BCD digits (minutes, seconds, hundredths) and drives a time-multiplexed 6-digit common-anode/cathode 7-segment display. Adds a lap-hold snapshot so the display can be frozen while counting continues. All outputs are registered and the block is fully synchronous to the stopwatch clock.

---
 rtl/stopwatch_display_scan.sv | 124 ++++++++++++
 tb/tb_stopwatch_display_scan.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_scan.sv
// Time-multiplexed 6-digit 7-segment driver for the stopwatch counter, with a
// lap-hold snapshot that freezes the display while counting continues.
module stopwatch_display_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       LAP,
  input  logic [3:0] MSH,
  input  logic [3:0] MSL,
  input  logic [3:0] SH,
  input  logic [3:0] SL,
  input  logic [3:0] MH,
  input  logic [3:0] ML,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [5:0] AN,
  output logic       HOLD
);

  localparam int             PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PLAST = PW'(SCAN_DIV - 1);
  localparam logic           INV   = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0] r_presc_p0;
  logic [2:0]    r_idx_p0;
  logic          r_hold_p0;
  logic [23:0]   r_snap_p0;

  logic [6:0]    r_seg_p1;
  logic          r_dp_p1;
  logic [5:0]    r_an_p1;

  logic          w_tick;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic [5:0]    w_an;

  // Active-high segment code {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h40;
    endcase
    return code;
  endfunction

  assign w_tick = (r_presc_p0 == PLAST);

  // Stage p0 -> p1: select the active digit from the snapshot and encode it.
  always_comb begin
    w_nib = 4'd0;
    case (r_idx_p0)
      3'd0:    w_nib = r_snap_p0[3:0];
      3'd1:    w_nib = r_snap_p0[7:4];
      3'd2:    w_nib = r_snap_p0[11:8];
      3'd3:    w_nib = r_snap_p0[15:12];
      3'd4:    w_nib = r_snap_p0[19:16];
      3'd5:    w_nib = r_snap_p0[23:20];
      default: w_nib = 4'd0;
    endcase

    w_an  = 6'b000001 << r_idx_p0;
    w_dp  = (r_idx_p0 == 3'd2) || (r_idx_p0 == 3'd4);
    w_seg = seg_decode(w_nib);
    if ((BLANK_LZ != 0) && (r_idx_p0 == 3'd5) && (w_nib == 4'd0)) begin
      w_seg = 7'h00;
    end
  end

  // Stage p0: prescaler, digit index, hold flag and snapshot.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_presc_p0 <= '0;
      r_idx_p0   <= 3'd0;
      r_hold_p0  <= 1'b0;
      r_snap_p0  <= 24'h0;
    end else begin
      r_presc_p0 <= w_tick ? '0 : r_presc_p0 + PW'(1);
      if (w_tick) begin
        r_idx_p0 <= (r_idx_p0 == 3'd5) ? 3'd0 : r_idx_p0 + 3'd1;
      end
      if (LAP) begin
        r_hold_p0 <= ~r_hold_p0;
      end
      // A LAP pulse always captures the live time, whether entering or leaving hold.
      if (!r_hold_p0 || LAP) begin
        r_snap_p0 <= {MH, ML, SH, SL, MSH, MSL};
      end
    end
  end

  // Stage p1: registered, polarity-adjusted display drive.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_seg_p1 <= {7{INV}};
      r_dp_p1  <= INV;
      r_an_p1  <= {6{INV}};
    end else begin
      r_seg_p1 <= w_seg ^ {7{INV}};
      r_dp_p1  <= w_dp ^ INV;
      r_an_p1  <= w_an ^ {6{INV}};
    end
  end

  assign SEG  = r_seg_p1;
  assign DP   = r_dp_p1;
  assign AN   = r_an_p1;
  assign HOLD = r_hold_p0;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Randomized bench for stopwatch_display_scan: three builds share stimulus and
// are compared every cycle against a frame-arithmetic reference model.
module tb_stopwatch_display_scan;

  logic       CLK = 1'b0;
  logic       CLR, LAP;
  logic [3:0] MSH, MSL, SH, SL, MH, ML;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [5:0] an_a, an_b, an_c;
  logic       hold_a, hold_b, hold_c;

  always #5 CLK = ~CLK;

  stopwatch_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) u_a (
    .CLK(CLK), .CLR(CLR), .LAP(LAP), .MSH(MSH), .MSL(MSL), .SH(SH), .SL(SL),
    .MH(MH), .ML(ML), .SEG(seg_a), .DP(dp_a), .AN(an_a), .HOLD(hold_a));

  stopwatch_display_scan #(.SCAN_DIV(3), .SEG_ACTIVE_LOW(0), .BLANK_LZ(1)) u_b (
    .CLK(CLK), .CLR(CLR), .LAP(LAP), .MSH(MSH), .MSL(MSL), .SH(SH), .SL(SL),
    .MH(MH), .ML(ML), .SEG(seg_b), .DP(dp_b), .AN(an_b), .HOLD(hold_b));

  stopwatch_display_scan #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(0), .BLANK_LZ(0)) u_c (
    .CLK(CLK), .CLR(CLR), .LAP(LAP), .MSH(MSH), .MSL(MSL), .SH(SH), .SL(SL),
    .MH(MH), .ML(ML), .SEG(seg_c), .DP(dp_c), .AN(an_c), .HOLD(hold_c));

  int n_tot = 0;
  int n_bad = 0;

  // Reference model: cycles elapsed since reset release, lap state, frozen digits.
  int         m_cnt;
  bit         m_hold;
  logic [3:0] m_dig[6];
  logic [6:0] seg_tab[10];
  logic [13:0] exp_o[3];
  bit          exp_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [13:0] ref_out(input int div, input bit al, input bit blz, input bit rst);
    logic [5:0] an;
    logic [6:0] sg;
    logic       dp;
    int         d;
    an = 6'h00; sg = 7'h00; dp = 1'b0;
    if (!rst) begin
      d  = (m_cnt / div) % 6;
      an = 6'(1 << d);
      sg = (m_dig[d] > 4'd9) ? 7'h40 : seg_tab[m_dig[d]];
      if (blz && d == 5 && m_dig[d] == 4'd0) sg = 7'h00;
      dp = (d == 2 || d == 4);
    end
    return al ? ~{an, sg, dp} : {an, sg, dp};
  endfunction

  task automatic model_edge();
    exp_o[0] = ref_out(4, 1'b1, 1'b1, CLR);
    exp_o[1] = ref_out(3, 1'b0, 1'b1, CLR);
    exp_o[2] = ref_out(1, 1'b0, 1'b0, CLR);
    if (CLR) begin
      m_cnt  = 0;
      m_hold = 1'b0;
      for (int i = 0; i < 6; i++) m_dig[i] = 4'd0;
    end else begin
      m_cnt++;
      if (!m_hold || LAP) begin
        m_dig[0] = MSL; m_dig[1] = MSH; m_dig[2] = SL;
        m_dig[3] = SH;  m_dig[4] = ML;  m_dig[5] = MH;
      end
      if (LAP) m_hold = !m_hold;
    end
    exp_hold = m_hold;
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    chk("an_a",  an_a,  exp_o[0][13:8]); chk("seg_a", seg_a, exp_o[0][7:1]);
    chk("dp_a",  dp_a,  exp_o[0][0]);    chk("hold_a", hold_a, exp_hold);
    chk("an_b",  an_b,  exp_o[1][13:8]); chk("seg_b", seg_b, exp_o[1][7:1]);
    chk("dp_b",  dp_b,  exp_o[1][0]);    chk("hold_b", hold_b, exp_hold);
    chk("an_c",  an_c,  exp_o[2][13:8]); chk("seg_c", seg_c, exp_o[2][7:1]);
    chk("dp_c",  dp_c,  exp_o[2][0]);    chk("hold_c", hold_c, exp_hold);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_time(input logic [3:0] mh, ml, sh, sl, msh, msl);
    MH = mh; ML = ml; SH = sh; SL = sl; MSH = msh; MSL = msl;
  endtask

  function automatic logic [3:0] rnd_nib();
    return ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
  endfunction

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    m_cnt = 0; m_hold = 1'b0;
    for (int i = 0; i < 6; i++) m_dig[i] = 4'd0;
    CLR = 1'b1; LAP = 1'b0;
    set_time(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);

    // Reset held for three cycles, with LAP asserted to confirm CLR wins.
    LAP = 1'b1;
    run(3);
    chk("rst_an",   an_a,   6'h3F);
    chk("rst_seg",  seg_a,  7'h7F);
    chk("rst_dp",   dp_a,   1'b1);
    chk("rst_hold", hold_a, 1'b0);
    chk("rst_an_hi", an_b,  6'h00);

    // Static scan and decode.
    CLR = 1'b0; LAP = 1'b0;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    cyc();
    chk("first_an", an_a, 6'h3E);
    run(60);

    // Leading-zero blank on minutes tens and dash on a non-BCD digit.
    set_time(4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'hA);
    run(60);

    // Lap hold: freeze SL=3, then step it to 7 while frozen, then release.
    set_time(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    run(5);
    LAP = 1'b1; cyc(); LAP = 1'b0;
    chk("hold_set", hold_a, 1'b1);
    SL = 4'd7;
    run(40);
    LAP = 1'b1; cyc(); LAP = 1'b0;
    chk("hold_clr", hold_a, 1'b0);
    run(40);

    // CLR and LAP together mid-scan while held.
    LAP = 1'b1; cyc(); LAP = 1'b0;
    run(9);
    CLR = 1'b1; LAP = 1'b1; cyc();
    chk("prio_hold", hold_a, 1'b0);
    chk("prio_an",   an_a,   6'h3F);
    CLR = 1'b0; LAP = 1'b0;
    cyc();
    chk("prio_restart", an_a, 6'h3E);
    run(30);

    // Randomized traffic with sporadic laps and resets.
    for (int i = 0; i < 1500; i++) begin
      set_time(rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib());
      LAP = ($urandom_range(0, 19) == 0);
      CLR = ($urandom_range(0, 99) == 0);
      cyc();
    end
    CLR = 1'b0; LAP = 1'b0;
    run(10);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
